pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the five-stage core: generates stall, bubble, flush, redirect and halt controls for the fetch, decode and execute stages. It detects load-use hazards between the decode-stage sources and the execute-stage load target, and drains the pipeline on exceptions. It arbitrates PC redirects between taken branches and exception vectors, and holds the core in halt. Sits beside decode; its stall/flush outputs drive decode's stall/flush/halt inputs directly.

Parameters:
LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..7)
DRAIN_CYCLES, 2, flush cycles before an exception redirect is issued (1..7)
VEC_BASE, 32'h0000_0400, exception vector base address
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
d_valid  in  1  decode stage holds a real (non-bubble) instruction
d_s_1  in  5  decode source register 1 (0 = unused)
d_s_2  in  5  decode source register 2 (0 = unused)
x_valid  in  1  execute stage holds a real instruction
x_is_load  in  1  execute instruction is a load
x_tgt  in  5  execute load destination register
x_br_taken  in  1  execute resolved a taken branch this cycle
x_br_target  in  32  branch target PC
w_exc  in  8  writeback exception code (0 = none)
w_halt  in  1  writeback retired a halt
mem_busy  in  1  memory port not ready; freeze whole pipe
stall  out  1  freeze fetch and decode
bubble_x  out  1  insert bubble into execute
flush  out  1  squash fetch/decode contents
redirect_valid  out  1  load PC from redirect_pc this cycle
redirect_pc  out  32  new PC
halt  out  1  pipeline halted
stall_count  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset (async, rst_n=0): state=RUN, counters cleared, stall_count=0; all outputs 0.
- States: RUN, LD_STALL, DRAIN, HALTED. The stall, bubble_x, flush and redirect outputs are combinational from state plus inputs. State and counters are registered.
- Hazard: hz = d_valid & x_valid & x_is_load & x_tgt!=0 & (x_tgt==d_s_1 | x_tgt==d_s_2). Register 0 never hazards.
- Priority per cycle, highest first: w_halt, w_exc!=0, x_br_taken, hz, mem_busy.
- RUN:
  - w_halt: halt=1, flush=1 → HALTED.
  - w_exc!=0: flush=1, latch code, load drain counter with DRAIN_CYCLES-1 → DRAIN.
  - x_br_taken: flush=1, redirect_valid=1, redirect_pc=x_br_target; stays RUN. Any hazard this cycle is ignored because it is squashed.
  - hz: stall=1, bubble_x=1. If LOAD_LAT>1, load counter with LOAD_LAT-1 → LD_STALL.
- LD_STALL: stall=1, bubble_x=1. Counter decrements each cycle; at 0 → RUN next cycle. Exception or halt preempts exactly as in RUN. A branch cannot occur here because execute holds a bubble.
- DRAIN: flush=1 every cycle, and branches are ignored.
  - When the counter reaches 0: redirect_valid=1, redirect_pc=VEC_BASE + {code,2'b00} (32-bit, wraps), flush=1 → RUN.
  - w_halt during DRAIN → HALTED.
  - A new w_exc during DRAIN is ignored; first exception wins.
- HALTED: halt=1, stall=1. All other outputs 0 and all inputs ignored until reset.
- mem_busy in RUN/LD_STALL with no higher event: stall=1, bubble_x=0, and the LD_STALL counter freezes. mem_busy does not delay DRAIN or its redirect.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Reset mid-DRAIN or mid-LD_STALL returns to RUN with no redirect issued.

Decomposition:
- Package pipe_pkg: state enum, REG_ZERO constant, EXC_NONE=8'h00, and the priority encoding.
- One sub-module, sat_counter (CNT_W, enable, async reset), is used for stall_count.
- The hazard comparator stays inline.

Test Plan:
- Load-use: x_is_load, x_tgt=5, d_s_2=5, LOAD_LAT=1 → stall=bubble_x=1 for exactly 1 cycle. With x_tgt=0 → no stall.
- LOAD_LAT=3 hazard with mem_busy high in cycle 2 → stall held 4 cycles total, bubble_x=1 in 3 of them, stall_count=4.
- Same-cycle x_br_taken with target 0x100 and hz → flush=1, redirect_pc=0x100, stall=0.
- w_exc=0x80 → flush 2 cycles, then redirect_valid=1, redirect_pc=0x600. A second w_exc=0x81 during the drain is ignored.
- w_halt → halt=1 persists 100 cycles despite branches and exceptions; rst_n low clears halt asynchronously.
- Assert rst_n low mid-DRAIN → no redirect, all outputs 0, state RUN after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: FSM states, event priority
// encoding and the register-zero / no-exception sentinels.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  // Highest-priority event seen this cycle; EV_HALT outranks everything.
  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_BUSY = 3'd1,
    EV_HZ   = 3'd2,
    EV_BR   = 3'd3,
    EV_EXC  = 3'd4,
    EV_HALT = 3'd5
  } event_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [7:0] EXC_NONE = 8'h00;

  function automatic event_t prio_encode(input logic halt, input logic exc,
                                         input logic br, input logic hz,
                                         input logic busy);
    event_t ev;
    if (halt)      ev = EV_HALT;
    else if (exc)  ev = EV_EXC;
    else if (br)   ev = EV_BR;
    else if (hz)   ev = EV_HZ;
    else if (busy) ev = EV_BUSY;
    else           ev = EV_NONE;
    return ev;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline status inputs and control outputs around pipe_ctrl.
// The master side drives stage status; the slave side is the sequencer.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             d_valid;
  logic [4:0]       d_s_1;
  logic [4:0]       d_s_2;
  logic             x_valid;
  logic             x_is_load;
  logic [4:0]       x_tgt;
  logic             x_br_taken;
  logic [31:0]      x_br_target;
  logic [7:0]       w_exc;
  logic             w_halt;
  logic             mem_busy;
  logic             stall;
  logic             bubble_x;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             halt;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output d_valid, d_s_1, d_s_2, x_valid, x_is_load, x_tgt,
           x_br_taken, x_br_target, w_exc, w_halt, mem_busy,
    input  stall, bubble_x, flush, redirect_valid, redirect_pc, halt, stall_count
  );

  modport slave (
    input  d_valid, d_s_1, d_s_2, x_valid, x_is_load, x_tgt,
           x_br_taken, x_br_target, w_exc, w_halt, mem_busy,
    output stall, bubble_x, flush, redirect_valid, redirect_pc, halt, stall_count
  );
endinterface

// File: rtl/sat_counter.sv
// Free-running up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (i_en && (r_count != '1))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: load-use stalls, exception drain with vectored
// redirect, branch redirect arbitration and halt hold.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int          LOAD_LAT     = 1,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] VEC_BASE     = 32'h0000_0400,
  parameter int          CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  pipe_ctrl_if.slave bus
);

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic [7:0]  r_code;
  logic [7:0]  w_code_next;
  logic        w_hz;
  event_t      w_ev;

  logic        w_stall;
  logic        w_bubble_x;
  logic        w_flush;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_halt_out;

  assign w_hz = bus.d_valid & bus.x_valid & bus.x_is_load &
                (bus.x_tgt != REG_ZERO) &
                ((bus.x_tgt == bus.d_s_1) | (bus.x_tgt == bus.d_s_2));

  // Execute holds a bubble in LD_STALL, so a branch there can only be noise.
  assign w_ev = prio_encode(bus.w_halt, bus.w_exc != EXC_NONE,
                            bus.x_br_taken & (r_state == ST_RUN),
                            w_hz, bus.mem_busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_code  <= EXC_NONE;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_code  <= w_code_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_code_next      = r_code;
    w_stall          = 1'b0;
    w_bubble_x       = 1'b0;
    w_flush          = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'h0;
    w_halt_out       = 1'b0;

    case (r_state)
      ST_RUN, ST_LD_STALL: begin
        case (w_ev)
          EV_HALT: begin
            w_halt_out   = 1'b1;
            w_flush      = 1'b1;
            w_state_next = ST_HALTED;
          end
          EV_EXC: begin
            w_flush      = 1'b1;
            w_code_next  = bus.w_exc;
            w_cnt_next   = 3'(DRAIN_CYCLES - 1);
            w_state_next = ST_DRAIN;
          end
          EV_BR: begin
            w_flush          = 1'b1;
            w_redirect_valid = 1'b1;
            w_redirect_pc    = bus.x_br_target;
          end
          EV_BUSY: begin
            // Whole pipe frozen: the load-stall countdown holds its value.
            w_stall = 1'b1;
          end
          default: begin
            if (r_state == ST_LD_STALL) begin
              w_stall    = 1'b1;
              w_bubble_x = 1'b1;
              w_cnt_next = r_cnt - 3'd1;
              if (r_cnt <= 3'd1)
                w_state_next = ST_RUN;
            end else if (w_ev == EV_HZ) begin
              w_stall    = 1'b1;
              w_bubble_x = 1'b1;
              if (LOAD_LAT > 1) begin
                w_cnt_next   = 3'(LOAD_LAT - 1);
                w_state_next = ST_LD_STALL;
              end
            end
          end
        endcase
      end
      ST_DRAIN: begin
        w_flush = 1'b1;
        if (bus.w_halt) begin
          w_halt_out   = 1'b1;
          w_state_next = ST_HALTED;
        end else if (r_cnt == 3'd0) begin
          w_redirect_valid = 1'b1;
          w_redirect_pc    = VEC_BASE + {22'b0, r_code, 2'b00};
          w_state_next     = ST_RUN;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      default: begin
        w_halt_out = 1'b1;
        w_stall    = 1'b1;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_stall),
    .o_count (bus.stall_count)
  );

  assign bus.stall          = w_stall;
  assign bus.bubble_x       = w_bubble_x;
  assign bus.flush          = w_flush;
  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.halt           = w_halt_out;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one LOAD_LAT=1 and one LOAD_LAT=3 instance
// share clock, reset and stimulus; each task checks one scenario.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        d_valid, x_valid, x_is_load, x_br_taken, w_halt, mem_busy;
  logic [4:0]  d_s_1, d_s_2, x_tgt;
  logic [31:0] x_br_target;
  logic [7:0]  w_exc;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl_if #(.CNT_W(16)) if1 ();
  pipe_ctrl_if #(.CNT_W(16)) if3 ();

  assign if1.d_valid = d_valid;     assign if3.d_valid = d_valid;
  assign if1.d_s_1 = d_s_1;         assign if3.d_s_1 = d_s_1;
  assign if1.d_s_2 = d_s_2;         assign if3.d_s_2 = d_s_2;
  assign if1.x_valid = x_valid;     assign if3.x_valid = x_valid;
  assign if1.x_is_load = x_is_load; assign if3.x_is_load = x_is_load;
  assign if1.x_tgt = x_tgt;         assign if3.x_tgt = x_tgt;
  assign if1.x_br_taken = x_br_taken;   assign if3.x_br_taken = x_br_taken;
  assign if1.x_br_target = x_br_target; assign if3.x_br_target = x_br_target;
  assign if1.w_exc = w_exc;         assign if3.w_exc = w_exc;
  assign if1.w_halt = w_halt;       assign if3.w_halt = w_halt;
  assign if1.mem_busy = mem_busy;   assign if3.mem_busy = mem_busy;

  pipe_ctrl #(.LOAD_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  pipe_ctrl #(.LOAD_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    d_valid = 0; x_valid = 0; x_is_load = 0; x_br_taken = 0; w_halt = 0; mem_busy = 0;
    d_s_1 = 0; d_s_2 = 0; x_tgt = 0; x_br_target = 0; w_exc = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic set_hazard();
    d_valid = 1; x_valid = 1; x_is_load = 1; x_tgt = 5'd5; d_s_1 = 5'd3; d_s_2 = 5'd5;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({if1.stall, if1.bubble_x, if1.flush, if1.redirect_valid, if1.halt} !== 5'b0 ||
        if1.redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %b pc=%h, want 00000 pc=0",
        {if1.stall, if1.bubble_x, if1.flush, if1.redirect_valid, if1.halt}, if1.redirect_pc);
    end
    n_tests++;
    if (if1.stall_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d, want 0", if1.stall_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    $display("[TB] test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    set_hazard();
    @(negedge clk);
    n_tests++;
    if (if1.stall !== 1'b1 || if1.bubble_x !== 1'b1 || if1.flush !== 1'b0) begin
      n_fail++; $display("FAIL ld_use_stall: got stall=%b bub=%b flush=%b, want 1 1 0",
        if1.stall, if1.bubble_x, if1.flush);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (if1.stall !== 1'b0 || if1.bubble_x !== 1'b0) begin
      n_fail++; $display("FAIL ld_use_one_cycle: got stall=%b bub=%b, want 0 0",
        if1.stall, if1.bubble_x);
    end
    next_cycle();
    set_hazard();
    x_tgt = 5'd0; d_s_1 = 5'd0; d_s_2 = 5'd0;
    @(negedge clk);
    n_tests++;
    if (if1.stall !== 1'b0 || if1.bubble_x !== 1'b0) begin
      n_fail++; $display("FAIL ld_use_r0: got stall=%b bub=%b, want 0 0",
        if1.stall, if1.bubble_x);
    end
    next_cycle();
    clear_inputs();
    $display("[TB] test_load_use done");
  endtask

  task automatic test_lat3_busy();
    logic [1:0] exp [4];
    exp[0] = 2'b11; exp[1] = 2'b10; exp[2] = 2'b11; exp[3] = 2'b11;
    do_reset();
    set_hazard();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (i < 4) begin
        if ({if3.stall, if3.bubble_x} !== exp[i]) begin
          n_fail++; $display("FAIL lat3_cycle%0d: got stall/bub=%b, want %b",
            i, {if3.stall, if3.bubble_x}, exp[i]);
        end
      end else if ({if3.stall, if3.bubble_x} !== 2'b00 || if3.stall_count !== 16'd4) begin
        n_fail++; $display("FAIL lat3_end: got stall/bub=%b count=%0d, want 00 count=4",
          {if3.stall, if3.bubble_x}, if3.stall_count);
      end
      next_cycle();
      clear_inputs();
      mem_busy = (i == 0);
    end
    clear_inputs();
    $display("[TB] test_lat3_busy done");
  endtask

  task automatic test_branch_hz();
    do_reset();
    set_hazard();
    x_br_taken = 1; x_br_target = 32'h0000_0100;
    @(negedge clk);
    n_tests++;
    if (if1.flush !== 1'b1 || if1.redirect_valid !== 1'b1 || if1.redirect_pc !== 32'h100 ||
        if1.stall !== 1'b0 || if1.bubble_x !== 1'b0) begin
      n_fail++; $display("FAIL branch_hz: got flush=%b rv=%b pc=%h stall=%b bub=%b, want 1 1 00000100 0 0",
        if1.flush, if1.redirect_valid, if1.redirect_pc, if1.stall, if1.bubble_x);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (if1.redirect_valid !== 1'b0 || if1.flush !== 1'b0) begin
      n_fail++; $display("FAIL branch_after: got rv=%b flush=%b, want 0 0",
        if1.redirect_valid, if1.flush);
    end
    next_cycle();
    $display("[TB] test_branch_hz done");
  endtask

  task automatic test_exception();
    do_reset();
    w_exc = 8'h80;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (i < 2) begin
        if (if1.flush !== 1'b1 || if1.redirect_valid !== 1'b0) begin
          n_fail++; $display("FAIL exc_drain%0d: got flush=%b rv=%b, want 1 0",
            i, if1.flush, if1.redirect_valid);
        end
      end else if (i == 2) begin
        if (if1.flush !== 1'b1 || if1.redirect_valid !== 1'b1 || if1.redirect_pc !== 32'h600) begin
          n_fail++; $display("FAIL exc_redirect: got flush=%b rv=%b pc=%h, want 1 1 00000600",
            if1.flush, if1.redirect_valid, if1.redirect_pc);
        end
      end else if (if1.flush !== 1'b0 || if1.redirect_valid !== 1'b0) begin
        n_fail++; $display("FAIL exc_back_run: got flush=%b rv=%b, want 0 0",
          if1.flush, if1.redirect_valid);
      end
      next_cycle();
      clear_inputs();
      if (i == 0) begin
        w_exc = 8'h81; x_br_taken = 1; x_br_target = 32'h100;
      end
    end
    $display("[TB] test_exception done");
  endtask

  task automatic test_halt();
    int bad;
    do_reset();
    w_halt = 1;
    @(negedge clk);
    n_tests++;
    if (if1.halt !== 1'b1 || if1.flush !== 1'b1) begin
      n_fail++; $display("FAIL halt_enter: got halt=%b flush=%b, want 1 1", if1.halt, if1.flush);
    end
    next_cycle();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      clear_inputs();
      case (i % 3)
        0: begin x_br_taken = 1; x_br_target = 32'h200; end
        1: w_exc = 8'h11;
        default: set_hazard();
      endcase
      @(negedge clk);
      if (if1.halt !== 1'b1 || if1.stall !== 1'b1 || if1.flush !== 1'b0 ||
          if1.redirect_valid !== 1'b0 || if1.bubble_x !== 1'b0)
        bad++;
      next_cycle();
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL halt_hold: got %0d bad cycles of 100, want 0", bad);
    end
    clear_inputs();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (if1.halt !== 1'b0 || if1.stall !== 1'b0) begin
      n_fail++; $display("FAIL halt_async_clear: got halt=%b stall=%b, want 0 0",
        if1.halt, if1.stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    $display("[TB] test_halt done");
  endtask

  task automatic test_reset_mid_drain();
    int bad;
    do_reset();
    w_exc = 8'h80;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if1.stall, if1.bubble_x, if1.flush, if1.redirect_valid, if1.halt} !== 5'b0) begin
      n_fail++; $display("FAIL drain_rst_outputs: got %b, want 00000",
        {if1.stall, if1.bubble_x, if1.flush, if1.redirect_valid, if1.halt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if1.redirect_valid !== 1'b0 || if1.flush !== 1'b0) bad++;
      next_cycle();
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL drain_rst_no_redirect: got %0d bad cycles, want 0", bad);
    end
    $display("[TB] test_reset_mid_drain done");
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    test_reset();
    test_load_use();
    test_lat3_busy();
    test_branch_hz();
    test_exception();
    test_halt();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
